// File: rtl/sat_pkg.sv
// Shared definitions for the DPLL SAT datapath.
//   SAT_VAR_W        : literal variable index width (matches the imply stack port)
//   SAT_NUM_VARIABLE : default depth of the variable-assignment table
//   literal_t        : {val, variable} literal as carried between blocks
//   bcp_state_e      : state encoding of the BCP propagator FSM
//   IS_RW_* / IS_TYPE_* : imply stack direction and entry-type encodings
package sat_pkg;

  localparam int SAT_VAR_W        = 9;
  localparam int SAT_NUM_VARIABLE = 128;

  typedef struct packed {
    logic                 val;
    logic [SAT_VAR_W-1:0] variable;
  } literal_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POP      = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RESOLVE  = 3'd3,
    ST_EMIT     = 3'd4,
    ST_DONE     = 3'd5,
    ST_CONFLICT = 3'd6
  } bcp_state_e;

  // Imply stack direction (is_rw) and entry type (is_type) encodings.
  localparam logic IS_RW_POP        = 1'b0;
  localparam logic IS_RW_PUSH       = 1'b1;
  localparam logic IS_TYPE_DECISION = 1'b0;
  localparam logic IS_TYPE_IMPLIED  = 1'b1;

endpackage

// File: rtl/assign_table.sv
// Variable-assignment register file: one assigned bit and one value bit per
// variable.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   wr_en/wr_variable/wr_val  : registered write, sets entry to assigned=1, value=wr_val
//   unassign_en/_variable     : registered clear of the assigned bit; wins over a
//                               write to the same variable in the same cycle
//   rd_variable               : combinational read address
//   rd_assigned/rd_val        : entry contents (0/0 for out-of-range addresses)
// Addresses >= NUM_VARIABLE are ignored on the write/unassign ports.
module assign_table
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE = SAT_NUM_VARIABLE,
  parameter int VAR_W        = SAT_VAR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [VAR_W-1:0] wr_variable,
  input  logic             wr_val,
  input  logic             unassign_en,
  input  logic [VAR_W-1:0] unassign_variable,
  input  logic [VAR_W-1:0] rd_variable,
  output logic             rd_assigned,
  output logic             rd_val
);

  localparam int IDX_W = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
  localparam logic [VAR_W:0] NUM_V = (VAR_W + 1)'(NUM_VARIABLE);

  logic [NUM_VARIABLE-1:0] assigned_q;
  logic [NUM_VARIABLE-1:0] value_q;

  logic             wr_in_range;
  logic             un_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] un_idx;
  logic [IDX_W-1:0] rd_idx;

  always_comb begin
    wr_in_range = ({1'b0, wr_variable} < NUM_V);
    un_in_range = ({1'b0, unassign_variable} < NUM_V);
    rd_in_range = ({1'b0, rd_variable} < NUM_V);
    wr_idx      = wr_variable[IDX_W-1:0];
    un_idx      = unassign_variable[IDX_W-1:0];
    rd_idx      = rd_variable[IDX_W-1:0];
  end

  // The unassign update is written last so it takes precedence on a collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      assigned_q <= '0;
      value_q    <= '0;
    end else begin
      if (wr_en && wr_in_range) begin
        assigned_q[wr_idx] <= 1'b1;
        value_q[wr_idx]    <= wr_val;
      end
      if (unassign_en && un_in_range) begin
        assigned_q[un_idx] <= 1'b0;
      end
    end
  end

  assign rd_assigned = rd_in_range ? assigned_q[rd_idx] : 1'b0;
  assign rd_val      = rd_in_range ? value_q[rd_idx]    : 1'b0;

endmodule

// File: rtl/bcp_propagator.sv
// Boolean-constraint-propagation consumer downstream of the imply stack.
// Pops implied literals, checks them against the assignment table and either
// commits them (and offers them downstream), discards redundant ones, or
// stops with a conflict.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   start, clear            : begin draining (IDLE/DONE) / return to IDLE (DONE/CONFLICT)
//   is_empty, is_en, is_rw  : imply stack status, pop enable, direction (always pop)
//   is_val/is_variable/is_type : popped entry, stable from RESOLVE onwards
//   dec_*, unassign_*       : decision write / backtrack unassign (only while idle)
//   asg_*                   : committed-assignment valid/ready output port
//   busy, done              : FSM activity / drained-without-conflict status
//   conflict, conflict_variable : sticky conflict flag and offending variable
//   err                     : sticky protocol error (cleared by reset only)
//   dbg_state               : current FSM state
//
// Handshake on asg_*: asg_valid rises with the payload already loaded and the
// payload is held unchanged while asg_valid=1; a transfer happens on each rising
// edge where asg_valid and asg_ready are both high, after which asg_valid drops.
// asg_valid never depends combinationally on asg_ready.
module bcp_propagator
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE = SAT_NUM_VARIABLE,
  parameter int VAR_W        = SAT_VAR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             is_empty,
  output logic             is_en,
  output logic             is_rw,
  input  logic             is_val,
  input  logic [VAR_W-1:0] is_variable,
  input  logic             is_type,
  input  logic             dec_en,
  input  logic [VAR_W-1:0] dec_variable,
  input  logic             dec_val,
  input  logic             unassign_en,
  input  logic [VAR_W-1:0] unassign_variable,
  output logic             asg_valid,
  input  logic             asg_ready,
  output logic [VAR_W-1:0] asg_variable,
  output logic             asg_val,
  output logic             busy,
  output logic             done,
  output logic             conflict,
  output logic [VAR_W-1:0] conflict_variable,
  output logic             err,
  output bcp_state_e       dbg_state
);

  localparam logic [VAR_W:0] NUM_V = (VAR_W + 1)'(NUM_VARIABLE);

  bcp_state_e       state_q;
  logic             asg_valid_q;
  logic [VAR_W-1:0] asg_variable_q;
  logic             asg_val_q;
  logic             conflict_q;
  logic [VAR_W-1:0] conflict_variable_q;
  logic             err_q;

  logic             rd_assigned;
  logic             rd_val;
  logic             in_range;
  logic             resolve_commit;
  logic             dec_ok;
  logic             unassign_ok;
  logic             proto_err;
  logic             tbl_wr_en;
  logic [VAR_W-1:0] tbl_wr_variable;
  logic             tbl_wr_val;

  assign busy = (state_q == ST_POP) || (state_q == ST_WAIT) ||
                (state_q == ST_RESOLVE) || (state_q == ST_EMIT);

  // The table has a single write port: the FSM commit and the decision strobe
  // share it, which is safe because decisions are only accepted while idle.
  always_comb begin
    in_range        = ({1'b0, is_variable} < NUM_V);
    resolve_commit  = (state_q == ST_RESOLVE) && in_range &&
                      (is_type == IS_TYPE_IMPLIED) && !rd_assigned;
    dec_ok          = dec_en && !busy && !unassign_en;
    unassign_ok     = unassign_en && !busy;
    proto_err       = ((dec_en || unassign_en) && busy) || (dec_en && unassign_en);
    tbl_wr_en       = resolve_commit || dec_ok;
    tbl_wr_variable = resolve_commit ? is_variable : dec_variable;
    tbl_wr_val      = resolve_commit ? is_val : dec_val;
  end

  assign_table #(
    .NUM_VARIABLE(NUM_VARIABLE),
    .VAR_W       (VAR_W)
  ) u_table (
    .clock            (clock),
    .reset            (reset),
    .wr_en            (tbl_wr_en),
    .wr_variable      (tbl_wr_variable),
    .wr_val           (tbl_wr_val),
    .unassign_en      (unassign_ok),
    .unassign_variable(unassign_variable),
    .rd_variable      (is_variable),
    .rd_assigned      (rd_assigned),
    .rd_val           (rd_val)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      asg_valid_q         <= 1'b0;
      asg_variable_q      <= '0;
      asg_val_q           <= 1'b0;
      conflict_q          <= 1'b0;
      conflict_variable_q <= '0;
      err_q               <= 1'b0;
    end else begin
      if (proto_err) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_POP;
        end
        ST_POP: begin
          // is_en is asserted combinationally for this cycle when not empty.
          state_q <= is_empty ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (!in_range || (is_type != IS_TYPE_IMPLIED)) begin
            err_q   <= 1'b1;
            state_q <= ST_POP;
          end else if (!rd_assigned) begin
            asg_valid_q    <= 1'b1;
            asg_variable_q <= is_variable;
            asg_val_q      <= is_val;
            state_q        <= ST_EMIT;
          end else if (rd_val == is_val) begin
            state_q <= ST_POP;
          end else begin
            conflict_q          <= 1'b1;
            conflict_variable_q <= is_variable;
            state_q             <= ST_CONFLICT;
          end
        end
        ST_EMIT: begin
          if (asg_ready) begin
            asg_valid_q <= 1'b0;
            state_q     <= ST_POP;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q <= ST_POP;
          end else if (clear) begin
            state_q <= ST_IDLE;
          end
        end
        ST_CONFLICT: begin
          if (clear) begin
            conflict_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign is_en             = (state_q == ST_POP) && !is_empty;
  assign is_rw             = IS_RW_POP;
  assign asg_valid         = asg_valid_q;
  assign asg_variable      = asg_variable_q;
  assign asg_val           = asg_val_q;
  assign done              = (state_q == ST_DONE);
  assign conflict          = conflict_q;
  assign conflict_variable = conflict_variable_q;
  assign err               = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_bcp_propagator.sv
module tb_bcp_propagator;
  import sat_pkg::*;

  localparam int VAR_W = SAT_VAR_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             is_empty = 1'b1;
  logic             is_en;
  logic             is_rw;
  logic             is_val = 1'b0;
  logic [VAR_W-1:0] is_variable = '0;
  logic             is_type = 1'b0;
  logic             dec_en = 1'b0;
  logic [VAR_W-1:0] dec_variable = '0;
  logic             dec_val = 1'b0;
  logic             unassign_en = 1'b0;
  logic [VAR_W-1:0] unassign_variable = '0;
  logic             asg_valid;
  logic             asg_ready = 1'b1;
  logic [VAR_W-1:0] asg_variable;
  logic             asg_val;
  logic             busy;
  logic             done;
  logic             conflict;
  logic [VAR_W-1:0] conflict_variable;
  logic             err;
  bcp_state_e       dbg_state;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  logic [VAR_W:0]   exp_q[$];   // {variable, val}
  logic [VAR_W+1:0] stk[$];     // {type, val, variable}; back = top

  bcp_propagator dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .clear            (clear),
    .is_empty         (is_empty),
    .is_en            (is_en),
    .is_rw            (is_rw),
    .is_val           (is_val),
    .is_variable      (is_variable),
    .is_type          (is_type),
    .dec_en           (dec_en),
    .dec_variable     (dec_variable),
    .dec_val          (dec_val),
    .unassign_en      (unassign_en),
    .unassign_variable(unassign_variable),
    .asg_valid        (asg_valid),
    .asg_ready        (asg_ready),
    .asg_variable     (asg_variable),
    .asg_val          (asg_val),
    .busy             (busy),
    .done             (done),
    .conflict         (conflict),
    .conflict_variable(conflict_variable),
    .err              (err),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- imply stack model ----------------
  always @(posedge clock) begin : stack_model
    logic [VAR_W+1:0] e;
    if (reset) begin
      stk.delete();
    end else if (is_en && (is_rw == IS_RW_POP)) begin
      total++;
      if (stk.size() == 0) begin
        bad++;
        $display("FAIL stack_underflow: pop with empty stack, required no pop");
      end else begin
        e = stk.pop_back();
        is_type     <= e[VAR_W+1];
        is_val      <= e[VAR_W];
        is_variable <= e[VAR_W-1:0];
      end
    end
  end

  always @(negedge clock) is_empty = (stk.size() == 0);

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : monitor
    logic [VAR_W:0] exp;
    if (!reset && asg_valid && asg_ready) begin
      xfers++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL asg_unexpected: got var=%0d val=%0d, required none", asg_variable, asg_val);
      end else begin
        exp = exp_q.pop_front();
        if ({asg_variable, asg_val} !== exp) begin
          bad++;
          $display("FAIL asg_payload: got var=%0d val=%0d, required var=%0d val=%0d",
                   asg_variable, asg_val, exp[VAR_W:1], exp[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_lit(input logic typ, input int var_i, input logic val);
    stk.push_back({typ, val, VAR_W'(var_i)});
  endtask

  task automatic expect_asg(input int var_i, input logic val);
    exp_q.push_back({VAR_W'(var_i), val});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_dec(input int var_i, input logic val);
    dec_en       = 1'b1;
    dec_variable = VAR_W'(var_i);
    dec_val      = val;
    tick();
    dec_en = 1'b0;
  endtask

  task automatic do_unassign(input int var_i);
    unassign_en       = 1'b1;
    unassign_variable = VAR_W'(var_i);
    tick();
    unassign_en = 1'b0;
  endtask

  function automatic logic cond_of(input int which);
    case (which)
      0:       return done;
      1:       return conflict;
      default: return asg_valid;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget);
    int n = 0;
    while (!cond_of(which) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(cond_of(which)), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stimulus
    int en_cnt;
    int stable_cnt;
    int xf0;

    do_reset();
    check("reset_outputs", 32'({is_en, is_rw, asg_valid, asg_variable, asg_val, busy,
                                done, conflict, conflict_variable, err}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_table", 32'((dut.u_table.assigned_q != '0) || (dut.u_table.value_q != '0)), 32'd0);

    // Drain to DONE, LIFO order, latency
    asg_ready = 1'b1;
    push_lit(1'b1, 5, 1'b1);
    push_lit(1'b1, 9, 1'b0);
    expect_asg(9, 1'b0);
    expect_asg(5, 1'b1);
    pulse_start();
    check("lat_is_en_c1", 32'(is_en), 32'd1);
    tick(); tick(); tick();
    check("lat_asg_valid_c4", 32'(asg_valid), 32'd1);
    wait_for("drain_done", 0, 30);
    check("drain_conflict", 32'(conflict), 32'd0);
    check("drain_xfers", 32'(xfers), 32'd2);
    check("tbl_5", 32'({dut.u_table.assigned_q[5], dut.u_table.value_q[5]}), 32'b11);
    check("tbl_9", 32'({dut.u_table.assigned_q[9], dut.u_table.value_q[9]}), 32'b10);
    pulse_clear();
    check("clear_done", 32'({done, busy}), 32'd0);

    // Redundant literal: POP, WAIT, RESOLVE, POP(empty), DONE
    do_dec(7, 1'b1);
    push_lit(1'b1, 7, 1'b1);
    xf0 = xfers;
    pulse_start();
    tick(); tick(); tick();
    check("redund_not_done_c4", 32'(done), 32'd0);
    tick();
    check("redund_done_c5", 32'(done), 32'd1);
    check("redund_no_xfer", 32'(xfers - xf0), 32'd0);
    pulse_clear();

    // Conflict: (3,1) committed, then (7,0) clashes with 7=1
    push_lit(1'b1, 7, 1'b0);
    push_lit(1'b1, 3, 1'b1);
    expect_asg(3, 1'b1);
    pulse_start();
    wait_for("conflict_seen", 1, 30);
    check("conflict_var", 32'(conflict_variable), 32'd7);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      en_cnt += int'(is_en);
    end
    check("conflict_is_en_quiet", 32'(en_cnt), 32'd0);
    check("conflict_state", 32'(dbg_state), 32'(ST_CONFLICT));
    pulse_clear();
    check("conflict_cleared", 32'(conflict), 32'd0);
    check("conflict_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("conflict_var_kept", 32'(conflict_variable), 32'd7);
    check("tbl_3", 32'({dut.u_table.assigned_q[3], dut.u_table.value_q[3]}), 32'b11);
    do_unassign(7);
    check("unassign_7", 32'(dut.u_table.assigned_q[7]), 32'd0);

    // Backpressure
    asg_ready = 1'b0;
    push_lit(1'b1, 13, 1'b0);
    push_lit(1'b1, 12, 1'b1);
    expect_asg(12, 1'b1);
    expect_asg(13, 1'b0);
    xf0 = xfers;
    pulse_start();
    wait_for("bp_valid", 2, 20);
    stable_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (asg_valid && asg_variable == VAR_W'(12) && asg_val == 1'b1) stable_cnt++;
    end
    check("bp_stable", 32'(stable_cnt), 32'd6);
    check("bp_no_xfer_yet", 32'(xfers - xf0), 32'd0);
    asg_ready = 1'b1;
    tick();
    check("bp_one_xfer", 32'(xfers - xf0), 32'd1);
    check("bp_valid_drop", 32'(asg_valid), 32'd0);
    check("bp_next_is_en", 32'(is_en), 32'd1);
    wait_for("bp_done", 0, 30);
    check("bp_total_xfers", 32'(xfers - xf0), 32'd2);
    pulse_clear();

    // Decision while busy
    check("err_clean", 32'(err), 32'd0);
    push_lit(1'b1, 20, 1'b1);
    expect_asg(20, 1'b1);
    pulse_start();
    do_dec(40, 1'b1);
    wait_for("busy_dec_done", 0, 30);
    check("busy_dec_err", 32'(err), 32'd1);
    check("busy_dec_tbl40", 32'(dut.u_table.assigned_q[40]), 32'd0);
    check("busy_dec_tbl20", 32'(dut.u_table.assigned_q[20]), 32'd1);
    pulse_clear();

    // Out-of-range variable
    do_reset();
    check("err_reset", 32'(err), 32'd0);
    push_lit(1'b1, 200, 1'b1);
    pulse_start();
    wait_for("oor_done", 0, 30);
    check("oor_err", 32'(err), 32'd1);
    check("oor_tbl", 32'(dut.u_table.assigned_q != '0), 32'd0);
    pulse_clear();

    // dec and unassign together: unassign wins
    do_reset();
    do_dec(50, 1'b1);
    dec_en = 1'b1; dec_variable = VAR_W'(51); dec_val = 1'b1;
    unassign_en = 1'b1; unassign_variable = VAR_W'(50);
    tick();
    dec_en = 1'b0; unassign_en = 1'b0;
    check("both_err", 32'(err), 32'd1);
    check("both_tbl", 32'({dut.u_table.assigned_q[50], dut.u_table.assigned_q[51]}), 32'd0);

    // Reset in the middle of EMIT
    do_reset();
    asg_ready = 1'b0;
    push_lit(1'b1, 30, 1'b1);
    pulse_start();
    wait_for("mid_emit_valid", 2, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs", 32'({is_en, is_rw, asg_valid, asg_variable, asg_val, busy,
                                    done, conflict, conflict_variable, err}), 32'd0);
    check("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_reset_table", 32'((dut.u_table.assigned_q != '0) || (dut.u_table.value_q != '0)), 32'd0);
    asg_ready = 1'b1;
    tick(); tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
